// File: rtl/mul_complex_pipe.sv
// Fully pipelined fixed-point complex multiplier, r = p*q or p*conj(q).
// Three stages share one enable: operand capture, four partial products,
// then combine/round/saturate. A valid/ready handshake provides backpressure.
module mul_complex_pipe #(
  parameter int DW    = 12,
  parameter int FRAC  = 10,
  parameter int ROUND = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_conj,
  input  logic [2*DW-1:0] p,
  input  logic [2*DW-1:0] q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*DW-1:0] r,
  output logic          out_ovf
);

  // Product width (DW x DW+1 signed) and sum width (one guard bit above that).
  localparam int PW = 2*DW + 1;
  localparam int SW = 2*DW + 2;

  localparam logic signed [SW-1:0] RND_C   = (ROUND != 0) ? SW'(1 << (FRAC-1)) : SW'(0);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DW-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  // Optional half-up rounding followed by a flooring arithmetic shift.
  function automatic logic signed [SW-1:0] rnd_shift(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = x + RND_C;
    return t >>> FRAC;
  endfunction

  // Clip to the DW-bit range; the MSB of the result flags a clip.
  function automatic logic [DW:0] sat(input logic signed [SW-1:0] x);
    if (x > SAT_MAX)      return {1'b1, SAT_MAX[DW-1:0]};
    else if (x < SAT_MIN) return {1'b1, SAT_MIN[DW-1:0]};
    else                  return {1'b0, x[DW-1:0]};
  endfunction

  // Sign-extend a DW-bit operand to product width.
  function automatic logic signed [PW-1:0] sx_dw(input logic signed [DW-1:0] x);
    return {{(PW-DW){x[DW-1]}}, x};
  endfunction

  logic w_en;
  logic vld_p0, vld_p1, vld_p2;

  // One enable for every stage: move whenever the output slot is free or being taken.
  assign w_en      = !vld_p2 | out_ready;
  assign in_ready  = w_en;
  assign out_valid = vld_p2;

  // Stage valid bits; the only state that needs a reset besides the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (w_en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- S1: operand capture, conjugate applied to q imag in DW+1 bits ----
  logic signed [DW-1:0] r_ar_p0, r_br_p0, r_aq_p0;
  logic signed [DW:0]   r_bq_p0;
  logic signed [DW:0]   w_bq_ext, w_bq_cj;

  assign w_bq_ext = $signed({q[DW-1], q[DW-1:0]});
  assign w_bq_cj  = in_conj ? -w_bq_ext : w_bq_ext;

  // Capture operands only on an accepted sample.
  always_ff @(posedge clk) begin
    if (w_en && in_valid) begin
      r_ar_p0 <= $signed(p[2*DW-1:DW]);
      r_br_p0 <= $signed(p[DW-1:0]);
      r_aq_p0 <= $signed(q[2*DW-1:DW]);
      r_bq_p0 <= w_bq_cj;
    end
  end

  // ---- S2: four signed partial products at full precision ----
  logic signed [PW-1:0] w_ar_x, w_br_x, w_aq_x, w_bq_x;
  logic signed [PW-1:0] r_m_rr_p1, r_m_ii_p1, r_m_ri_p1, r_m_ir_p1;

  assign w_ar_x = sx_dw(r_ar_p0);
  assign w_br_x = sx_dw(r_br_p0);
  assign w_aq_x = sx_dw(r_aq_p0);
  assign w_bq_x = {{(PW-DW-1){r_bq_p0[DW]}}, r_bq_p0};

  // Register products only when a valid sample advances into S2.
  always_ff @(posedge clk) begin
    if (w_en && vld_p0) begin
      r_m_rr_p1 <= w_ar_x * w_aq_x;
      r_m_ii_p1 <= w_br_x * w_bq_x;
      r_m_ri_p1 <= w_aq_x * w_br_x;
      r_m_ir_p1 <= w_ar_x * w_bq_x;
    end
  end

  // ---- S3: combine, round, shift, saturate ----
  logic signed [SW-1:0] w_re, w_im;
  logic [DW:0]          w_re_s, w_im_s;
  logic [2*DW-1:0]      r_res_p2;
  logic                 r_ovf_p2;

  assign w_re   = $signed({r_m_rr_p1[PW-1], r_m_rr_p1}) - $signed({r_m_ii_p1[PW-1], r_m_ii_p1});
  assign w_im   = $signed({r_m_ir_p1[PW-1], r_m_ir_p1}) + $signed({r_m_ri_p1[PW-1], r_m_ri_p1});
  assign w_re_s = sat(rnd_shift(w_re));
  assign w_im_s = sat(rnd_shift(w_im));

  // Output register: cleared on reset, updated only by a valid sample so it holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_p2 <= '0;
      r_ovf_p2 <= 1'b0;
    end else if (w_en && vld_p1) begin
      r_res_p2 <= {w_re_s[DW-1:0], w_im_s[DW-1:0]};
      r_ovf_p2 <= w_re_s[DW] | w_im_s[DW];
    end
  end

  assign r       = r_res_p2;
  assign out_ovf = r_ovf_p2;

endmodule
